// File: rtl/logic_unit_arbiter.sv
// Shares one W-bit bitwise logic unit (AND/OR/XOR/ANDN) between NREQ requesters.
// Round-robin by default; define LOGIC_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module logic_unit_arbiter #(
  parameter int NREQ = 2,
  parameter int W    = 32,
  parameter int IDW  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] op,
  input  logic [W*NREQ-1:0] lhs,
  input  logic [W*NREQ-1:0] rhs,
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_win;
  logic            arb_found;
  logic            grant_ok;
  logic            take;

  logic [1:0]      sel_op;
  logic [W-1:0]    sel_lhs;
  logic [W-1:0]    sel_rhs;

  logic [1:0]      op_q;
  logic [W-1:0]    lhs_q;
  logic [W-1:0]    rhs_q;
  logic [IDW-1:0]  win_q;
  logic [W-1:0]    result;

  // Grants are only offered while the unit is free; reset masks them entirely.
  assign grant_ok = rst_n && (state != EXEC);
  assign take     = grant_ok && arb_found;

`ifdef LOGIC_ARB_FIXED_PRIO_EN
  always_comb begin
    arb_gnt   = '0;
    arb_win   = '0;
    arb_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!arb_found && req[i]) begin
        arb_found  = 1'b1;
        arb_gnt[i] = 1'b1;
        arb_win    = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] rr_ptr;

  // Search starts one past the last winner, wrapping modulo NREQ.
  always_comb begin
    arb_gnt   = '0;
    arb_win   = '0;
    arb_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!arb_found && req[i] && (i == ((int'(rr_ptr) + k) % NREQ))) begin
          arb_found  = 1'b1;
          arb_gnt[i] = 1'b1;
          arb_win    = IDW'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= IDW'(NREQ - 1);
    end else if (take) begin
      rr_ptr <= arb_win;
    end
  end
`endif

  always_comb begin
    sel_op  = '0;
    sel_lhs = '0;
    sel_rhs = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        sel_op  = op[2*i +: 2];
        sel_lhs = lhs[W*i +: W];
        sel_rhs = rhs[W*i +: W];
      end
    end
  end

  always_comb begin
    case (op_q)
      2'b00:   result = lhs_q & rhs_q;
      2'b01:   result = lhs_q | rhs_q;
      2'b10:   result = lhs_q ^ rhs_q;
      default: result = lhs_q & ~rhs_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (grant_ok) gnt = arb_gnt;
        state_nxt = arb_found ? EXEC : IDLE;
      end
      EXEC: begin
        busy      = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (grant_ok) gnt = arb_gnt;
        state_nxt = arb_found ? EXEC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are captured at the grant edge so requesters may move on immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= '0;
      lhs_q    <= '0;
      rhs_q    <= '0;
      win_q    <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else begin
      if (take) begin
        op_q  <= sel_op;
        lhs_q <= sel_lhs;
        rhs_q <= sel_rhs;
        win_q <= arb_win;
      end
      if (state == EXEC) begin
        rsp_data <= result;
        rsp_id   <= win_q;
      end
    end
  end

endmodule
